cla_pipe_adder: RTL and testbench

CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

---
 rtl/cla_pipe_adder.sv | 111 +++++++++++
 tb/tb_cla_pipe_adder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined add/subtract built from 4-bit carry-lookahead groups,
// one SEG_W-bit slice per stage, valid/ready flow control with full-pipe stall.
module cla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);
  localparam int STAGES = WIDTH / SEG_W;

  if (WIDTH % SEG_W != 0 || SEG_W % 4 != 0) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
  end

  // Returns {carry_out, sum}; groups chain their lookahead carry-out into the next group.
  function automatic logic [SEG_W:0] seg_add(input logic [SEG_W-1:0] a, input logic [SEG_W-1:0] b,
                                            input logic ci);
    logic [SEG_W-1:0] s;
    logic [3:0] g, p, c;
    logic cg;
    cg = ci;
    s = '0;
    for (int j = 0; j < SEG_W / 4; j++) begin
      g = a[4*j +: 4] & b[4*j +: 4];
      p = a[4*j +: 4] ^ b[4*j +: 4];
      c[0] = cg;
      c[1] = g[0] | (p[0] & cg);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cg);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cg);
      cg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & cg);
      s[4*j +: 4] = p ^ c;
    end
    return {cg, s};
  endfunction

  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int RW = WIDTH - k * SEG_W;
    localparam int DW = (k + 1) * SEG_W;
    logic [RW-1:0] xa, ya;
    logic [DW-1:0] s_d, s_q;
    logic [SEG_W-1:0] sl;
    logic ca, va, cl, c_q, v_q;
    assign {cl, sl} = seg_add(xa[SEG_W-1:0], ya[SEG_W-1:0], ca);
    if (k == 0) begin : g_in
      assign xa  = X;
      assign ya  = sub ? ~Y : Y;
      assign ca  = sub | Cin;
      assign va  = in_valid;
      assign s_d = sl;
    end else begin : g_chain
      assign xa  = g_stg[k-1].g_fwd.x_q;
      assign ya  = g_stg[k-1].g_fwd.y_q;
      assign ca  = g_stg[k-1].c_q;
      assign va  = g_stg[k-1].v_q;
      assign s_d = {sl, g_stg[k-1].s_q};
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_d;
        c_q <= cl;
        v_q <= va;
      end
    end
    if (k < STAGES - 1) begin : g_fwd
      logic [RW-SEG_W-1:0] x_q, y_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0;
          y_q <= '0;
        end else if (adv) begin
          x_q <= xa[RW-1:SEG_W];
          y_q <= ya[RW-1:SEG_W];
        end
      end
    end else begin : g_out
      // a^b^s at the MSB recovers the carry into bit WIDTH-1
      logic o_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) o_q <= 1'b0;
        else if (adv) o_q <= xa[SEG_W-1] ^ ya[SEG_W-1] ^ sl[SEG_W-1] ^ cl;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign S         = g_stg[STAGES-1].s_q;
  assign Cout      = g_stg[STAGES-1].c_q;
  assign Ovf       = g_stg[STAGES-1].g_out.o_q;
  assign Zero      = out_valid & ~|S;
  assign in_ready  = !out_valid || out_ready;
  assign adv       = in_ready;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed checks of the pipelined CLA adder (32/8 and 16/16 builds).
module tb_cla_pipe_adder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, Cin = 1'b0, sub = 1'b0;
  logic [31:0] X = '0, Y = '0;
  logic in_ready, out_valid, Cout, Ovf, Zero;
  logic [31:0] S;
  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_Cout, b_Ovf, b_Zero;
  logic [15:0] b_X = '0, b_Y = '0, b_S;
  int checks = 0, fails = 0;

  cla_pipe_adder #(.WIDTH(32), .SEG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
    .Cin(Cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .S(S), .Cout(Cout),
    .Ovf(Ovf), .Zero(Zero));

  cla_pipe_adder #(.WIDTH(16), .SEG_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .X(b_X), .Y(b_Y),
    .Cin(1'b0), .sub(1'b0), .out_valid(b_out_valid), .out_ready(1'b1), .S(b_S), .Cout(b_Cout),
    .Ovf(b_Ovf), .Zero(b_Zero));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run1(input string t, input logic [31:0] x, input logic [31:0] y, input logic ci,
                      input logic sb, input logic [31:0] es, input logic ec, input logic eo,
                      input logic ez);
    X = x; Y = y; Cin = ci; sub = sb; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0; X = 32'hDEADBEEF; Y = 32'h12345678; sub = ~sb;
    step(2);
    chk({t, "_early"}, out_valid, 1'b0);
    step(1);
    chk({t, "_valid"}, out_valid, 1'b1);
    chk({t, "_s"}, S, es);
    chk({t, "_cout"}, Cout, ec);
    chk({t, "_ovf"}, Ovf, eo);
    chk({t, "_zero"}, Zero, ez);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    int ni, no, sl;
    bit seen;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_s", S, 32'h0);
    chk("rst_cout", Cout, 1'b0);
    chk("rst_ovf", Ovf, 1'b0);
    chk("rst_zero", Zero, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    b_X = 16'h8000; b_Y = 16'h8000; b_in_valid = 1'b1;
    step(1);
    b_in_valid = 1'b0;
    chk("w16_valid", b_out_valid, 1'b1);
    chk("w16_s", b_S, 16'h0);
    chk("w16_cout", b_Cout, 1'b1);
    chk("w16_ovf", b_Ovf, 1'b1);
    chk("w16_zero", b_Zero, 1'b1);
    run1("carry", 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    run1("sub", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run1("ovf", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    step(1);
    ni = 0; no = 0; sl = 0; seen = 0;
    Cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 40 && no < 6; cyc++) begin
      if (!seen && out_valid) begin
        seen = 1;
        sl = 3;
      end
      out_ready = (sl == 0);
      in_valid = (ni < 6);
      X = 32'(ni); Y = 32'(ni);
      #1;
      if (sl > 0) begin
        chk("stall_ready", in_ready, 1'b0);
        chk("stall_s", S, 32'h0);
        sl--;
      end
      if (out_valid && out_ready) begin
        chk("b2b_s", S, 64'(2 * no));
        no++;
      end
      if (in_valid && in_ready) ni++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("b2b_count", 64'(no), 64'd6);
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 8) && (c % 2 == 0);
      X = 32'(c); Y = 32'd1;
      step(1);
      chk("alt_valid", out_valid, (c >= 3) && (c - 3 < 8) && ((c - 3) % 2 == 0));
      if (c >= 3 && (c - 3) % 2 == 0 && c - 3 < 8) chk("alt_s", S, 64'(c - 2));
    end
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      X = 32'(i); Y = 32'd0; in_valid = 1'b1;
      step(1);
    end
    in_valid = 1'b0;
    chk("pre_rst_s", S, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_s", S, 32'h0);
    chk("arst_ready", in_ready, 1'b1);
    #3 rst_n = 1'b1;
    X = 32'd9; Y = 32'd3; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    chk("post_rst_stale1", out_valid, 1'b0);
    step(2);
    chk("post_rst_stale3", out_valid, 1'b0);
    step(1);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_s", S, 32'd12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
